// File: rtl/control_unit.sv
// Instruction sequencer for the 16-bit accumulator CPU: fetch/decode timing (T0-T5)
// and per-step datapath strobes decoded from the registered mode, step counter and IR.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_instr,
  input  logic        i_ac_pos,
  input  logic        i_ac_neg,
  input  logic        i_ac_zero,
  input  logic        i_e,
  input  logic        i_dr_zero,
  output logic [2:0]  o_sc,
  output logic [11:0] o_addr,
  output logic        o_read,
  output logic        o_write,
  output logic        o_we,
  output logic        o_reg_ref,
  output logic        o_mem_ref,
  output logic        o_ind_addr,
  output logic        o_clr_sc,
  output logic        o_clr_ac,
  output logic        o_clr_e,
  output logic        o_comp_ac,
  output logic        o_comp_e,
  output logic        o_cir_r,
  output logic        o_cir_l,
  output logic        o_inc_ac,
  output logic        o_skip,
  output logic        o_and,
  output logic        o_add,
  output logic        o_load,
  output logic        o_load_ac,
  output logic        o_store,
  output logic        o_branch,
  output logic        o_bsa,
  output logic        o_isz,
  output logic        o_is_idle
);

  typedef enum logic {IDLE, RUN} mode_t;

  mode_t       mode;
  logic [2:0]  sc;
  logic [15:0] ir;

  logic [2:0]  op;
  logic        ind;
  logic        rr;
  logic [3:0]  top_bit;
  logic        any_bit;
  logic [2:0]  last_step;
  logic        hlt;

  assign op  = ir[14:12];
  assign ind = ir[15];
  assign rr  = (op == 3'd7) && !ind;
  assign hlt = rr && (ir[11:0] == 12'h001);

  // Register-reference bits are prioritised: the highest set bit wins.
  always_comb begin
    top_bit = 4'd0;
    any_bit = 1'b0;
    for (int b = 0; b < 12; b++) begin
      if (ir[b]) begin
        top_bit = 4'(b);
        any_bit = 1'b1;
      end
    end
  end

  always_comb begin
    case (op)
      3'd3, 3'd4, 3'd7: last_step = 3'd3;
      3'd6:             last_step = 3'd5;
      default:          last_step = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= IDLE;
      sc   <= 3'd0;
      ir   <= 16'h0000;
    end else begin
      case (mode)
        IDLE: begin
          sc <= 3'd0;
          if (i_start) mode <= RUN;
        end
        RUN: begin
          if (sc == 3'd1) ir <= i_instr;
          // last_step is at least 3, so the stale IR seen during T0/T1 never ends an instruction
          if (sc == last_step) begin
            sc <= 3'd0;
            if (hlt) mode <= IDLE;
          end else begin
            sc <= sc + 3'd1;
          end
        end
        default: begin
          mode <= IDLE;
          sc   <= 3'd0;
        end
      endcase
    end
  end

  assign o_sc      = sc;
  assign o_addr    = ir[11:0];
  assign o_is_idle = (mode == IDLE);

  always_comb begin
    o_read = 1'b0;    o_write = 1'b0;   o_we = 1'b0;
    o_reg_ref = 1'b0; o_mem_ref = 1'b0; o_ind_addr = 1'b0;
    o_clr_sc = 1'b0;  o_clr_ac = 1'b0;  o_clr_e = 1'b0;
    o_comp_ac = 1'b0; o_comp_e = 1'b0;  o_cir_r = 1'b0;
    o_cir_l = 1'b0;   o_inc_ac = 1'b0;  o_skip = 1'b0;
    o_and = 1'b0;     o_add = 1'b0;     o_load = 1'b0;
    o_load_ac = 1'b0; o_store = 1'b0;   o_branch = 1'b0;
    o_bsa = 1'b0;     o_isz = 1'b0;
    if (mode == RUN) begin
      case (sc)
        3'd0: o_read = 1'b1;
        3'd1: ;
        3'd2: begin
          o_read     = (op != 3'd7) && ind;
          o_ind_addr = (op != 3'd7) && ind;
        end
        default: begin
          o_mem_ref = (op != 3'd7);
          o_reg_ref = rr;
          o_clr_sc  = (sc == last_step);
          case (op)
            3'd0, 3'd1, 3'd2: begin
              o_read    = (sc == 3'd3);
              o_and     = (sc == 3'd4) && (op == 3'd0);
              o_add     = (sc == 3'd4) && (op == 3'd1);
              o_load    = (sc == 3'd4) && (op == 3'd2);
              o_load_ac = (sc == 3'd4);
            end
            3'd3: begin
              o_write = 1'b1;
              o_we    = 1'b1;
              o_store = 1'b1;
            end
            3'd4: o_branch = 1'b1;
            3'd5: begin
              o_bsa    = (sc == 3'd3);
              o_write  = (sc == 3'd3);
              o_we     = (sc == 3'd3);
              o_branch = (sc == 3'd4);
            end
            3'd6: begin
              o_read  = (sc == 3'd3);
              o_isz   = (sc == 3'd4);
              o_write = (sc == 3'd5);
              o_we    = (sc == 3'd5);
              o_skip  = (sc == 3'd5) && i_dr_zero;
            end
            default: begin
              if (rr && any_bit) begin
                case (top_bit)
                  4'd11: o_clr_ac  = 1'b1;
                  4'd10: o_clr_e   = 1'b1;
                  4'd9:  o_comp_ac = 1'b1;
                  4'd8:  o_comp_e  = 1'b1;
                  4'd7:  o_cir_r   = 1'b1;
                  4'd6:  o_cir_l   = 1'b1;
                  4'd5:  o_inc_ac  = 1'b1;
                  4'd4:  o_skip    = i_ac_pos;
                  4'd3:  o_skip    = i_ac_neg;
                  4'd2:  o_skip    = i_ac_zero;
                  4'd1:  o_skip    = ~i_e;
                  default: ;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
